truth_table_sweeper: RTL and testbench

- Sequential stimulus-and-check engine for a small combinational function under test with an N_IN-bit input and a 1-bit output.
- On start, it walks the input bus through every combination 0 .. 2^N_IN-1, waits a settle time, and samples the function output.
- It builds a response mask and compares it bitwise against a parameterised expected truth table.
- It replaces hand-written initial-block stimulus with on-chip, self-checking sweep hardware.

---
 rtl/truth_table_sweeper.sv | 114 +++++++++++
 tb/tb_truth_table_sweeper.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Self-checking exhaustive sweep of a small combinational function:
// drives every input code, samples the response and scores it against a truth table.
module truth_table_sweeper #(
    parameter int                   N_IN        = 3,
    parameter int                   SETTLE      = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECT_MASK = 8'h45
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f_in,
    output logic [N_IN-1:0]        stim,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   resp_mask,
    output logic [N_IN:0]          fail_count,
    output logic [N_IN-1:0]        first_fail
);

    localparam int              SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'((1 << N_IN) - 1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [SW-1:0]   SET_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0]   SET_ONE  = SW'(1);
    localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        FINISH
    } state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [SW-1:0]   settle_cnt;
    logic            f_smp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            f_smp      <= 1'b0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            resp_mask  <= '0;
            fail_count <= '0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        stim       <= '0;
                        settle_cnt <= '0;
                        resp_mask  <= '0;
                        fail_count <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    settle_cnt <= settle_cnt + SET_ONE;
                    if (abort) begin
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt == SET_LAST) begin
                        // Capture exactly SETTLE cycles after stim changed.
                        f_smp <= f_in;
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    resp_mask[idx] <= f_smp;
                    if (f_smp != EXPECT_MASK[idx]) begin
                        fail_count <= fail_count + CNT_ONE;
                        if (fail_count == '0) begin
                            first_fail <= idx;
                        end
                    end
                    if (abort) begin
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        state <= FINISH;
                    end else begin
                        idx        <= idx + IDX_ONE;
                        stim       <= idx + IDX_ONE;
                        settle_cnt <= '0;
                        state      <= APPLY;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    pass  <= (fail_count == '0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of model modes plus
// restart, abort, start+abort and mid-sweep reset sequences.
module tb_truth_table_sweeper;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       f_in;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] resp_mask;
    logic [3:0] fail_count;
    logic [2:0] first_fail;

    truth_table_sweeper #(
        .N_IN(3),
        .SETTLE(2),
        .EXPECT_MASK(8'h45)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .f_in(f_in),
        .stim(stim),
        .busy(busy),
        .done(done),
        .pass(pass),
        .resp_mask(resp_mask),
        .fail_count(fail_count),
        .first_fail(first_fail)
    );

    always #5 clk = ~clk;

    // Function-under-test model: 0 good, 1 tied low, 2 inverted,
    // 3 wrong at code 6, 4 one-cycle delayed, 5 two-cycle delayed.
    logic [7:0] emask = 8'h45;
    int         mode  = 0;
    logic       m;
    logic       d1 = 1'b0;
    logic       d2 = 1'b0;

    assign m = emask[stim];

    always @(posedge clk) begin
        d1 <= m;
        d2 <= d1;
    end

    always_comb begin
        f_in = m;
        case (mode)
            1: f_in = 1'b0;
            2: f_in = ~m;
            3: f_in = (stim == 3'd6) ? ~m : m;
            4: f_in = d1;
            5: f_in = d2;
            default: f_in = m;
        endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, got, got, exp, exp);
        end
    endtask

    task automatic sweep(input int restart_at, input int abort_at,
                         output int done_cyc, output logic busy_at_done,
                         output logic done_after, output int walk_bad,
                         output logic busy_pre, output logic busy_post);
        done_cyc     = -1;
        busy_at_done = 1'b1;
        done_after   = 1'b1;
        walk_bad     = 0;
        busy_pre     = 1'b0;
        busy_post    = 1'b1;
        @(negedge clk);
        start = 1'b1;
        abort = (abort_at == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == restart_at);
            abort = (c == abort_at);
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            if (c % 3 == 1 && c <= 22 && int'(stim) != (c - 1) / 3)
                walk_bad++;
            if (c == abort_at - 1) busy_pre = busy;
            if (c == abort_at) busy_post = busy;
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                done_after = done;
                break;
            end
            if (done && done_cyc < 0) begin
                done_cyc     = c;
                busy_at_done = busy;
            end
        end
    endtask

    typedef struct {
        int         mode;
        logic       exp_pass;
        logic [7:0] exp_mask;
        int         exp_fc;
        int         exp_ff;
    } vec_t;

    vec_t tv[6];

    int   dc;
    int   wb;
    logic bd, da, bp, bq;

    initial begin
        tv[0] = '{0, 1'b1, 8'h45, 0, 0};
        tv[1] = '{1, 1'b0, 8'h00, 3, 0};
        tv[2] = '{2, 1'b0, 8'hBA, 8, 0};
        tv[3] = '{3, 1'b0, 8'h05, 1, 6};
        tv[4] = '{4, 1'b1, 8'h45, 0, 0};
        tv[5] = '{5, 1'b0, 8'h8A, 6, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_stim", int'(stim), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_mask", int'(resp_mask), 0);
        check("rst_fc", int'(fail_count), 0);
        check("rst_ff", int'(first_fail), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            mode = tv[i].mode;
            sweep(-1, -1, dc, bd, da, wb, bp, bq);
            check($sformatf("v%0d_done_cyc", i), dc, 25);
            check($sformatf("v%0d_busy_at_done", i), int'(bd), 0);
            check($sformatf("v%0d_done_pulse", i), int'(da), 0);
            check($sformatf("v%0d_stim_walk", i), wb, 0);
            check($sformatf("v%0d_pass", i), int'(pass), int'(tv[i].exp_pass));
            check($sformatf("v%0d_mask", i), int'(resp_mask), int'(tv[i].exp_mask));
            check($sformatf("v%0d_fc", i), int'(fail_count), tv[i].exp_fc);
            check($sformatf("v%0d_ff", i), int'(first_fail), tv[i].exp_ff);
            check($sformatf("v%0d_stim_final", i), int'(stim), 7);
        end

        mode = 0;
        sweep(10, -1, dc, bd, da, wb, bp, bq);
        check("restart_done_cyc", dc, 25);
        check("restart_pass", int'(pass), 1);

        sweep(-1, 12, dc, bd, da, wb, bp, bq);
        check("abort_no_done", dc, -1);
        check("abort_busy_pre", int'(bp), 1);
        check("abort_busy_post", int'(bq), 0);
        check("abort_pass", int'(pass), 0);

        sweep(-1, -1, dc, bd, da, wb, bp, bq);
        check("fresh_done_cyc", dc, 25);
        check("fresh_pass", int'(pass), 1);
        check("fresh_mask", int'(resp_mask), 8'h45);

        sweep(-1, 0, dc, bd, da, wb, bp, bq);
        check("start_abort_done_cyc", dc, 25);
        check("start_abort_pass", int'(pass), 1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        check("midrst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_stim", int'(stim), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_pass", int'(pass), 0);
        check("midrst_mask", int'(resp_mask), 0);
        check("midrst_fc", int'(fail_count), 0);
        check("midrst_ff", int'(first_fail), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(-1, -1, dc, bd, da, wb, bp, bq);
        check("postrst_done_cyc", dc, 25);
        check("postrst_pass", int'(pass), 1);
        check("postrst_mask", int'(resp_mask), 8'h45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
